// File: rtl/operand_entry_ctrl.sv
// Keypad-to-multiplier sequencer: builds two signed decimal operands from key
// strobes, launches the multiplier, waits for done (with timeout), shows product.
module operand_entry_ctrl #(
  parameter int OP_W       = 8,
  parameter int MAX_DIGITS = 2,
  parameter int TIMEOUT    = 1023
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              key_valid,
  input  logic [3:0]        key_code,
  input  logic              mult_done,
  input  logic [2*OP_W-1:0] mult_result,
  output logic [OP_W-1:0]   numero1_o,
  output logic [OP_W-1:0]   numero2_o,
  output logic              sel_op_o,
  output logic              mult_start,
  output logic              busy_o,
  output logic [2*OP_W-1:0] result_o,
  output logic              result_valid,
  output logic              err_o
);

  localparam int EW = OP_W + 4;
  localparam int MW = OP_W - 1;
  localparam int CW = $clog2(MAX_DIGITS + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_DIGITS);
  localparam logic [TW-1:0] TMO_MAX = TW'(TIMEOUT);

  localparam logic [3:0] KEY_ENTER = 4'hA;
  localparam logic [3:0] KEY_SIGN  = 4'hB;
  localparam logic [3:0] KEY_CLEAR = 4'hC;

  typedef enum logic [2:0] {S_OP1, S_OP2, S_START, S_WAIT, S_SHOW} state_e;

  state_e              state_q, state_d;
  logic [MW-1:0]       mag1_q, mag1_d, mag2_q, mag2_d;
  logic                sign1_q, sign1_d, sign2_q, sign2_d;
  logic [CW-1:0]       cnt1_q, cnt1_d, cnt2_q, cnt2_d;
  logic [OP_W-1:0]     numero1_q, numero1_d, numero2_q, numero2_d;
  logic [TW-1:0]       tmo_q, tmo_d;
  logic [2*OP_W-1:0]   result_q, result_d;
  logic                rv_q, rv_d, err_q, err_d;
  logic                is_digit;

  // Wide intermediate so mag*10+d never wraps before truncation.
  function automatic logic [MW-1:0] append_digit(input logic [MW-1:0] mag,
                                                  input logic [3:0]    d);
    logic [EW-1:0] wide;
    wide = EW'(mag) * EW'(10) + EW'(d);
    return wide[MW-1:0];
  endfunction

  function automatic logic [OP_W-1:0] to_tc(input logic sign, input logic [MW-1:0] mag);
    logic [OP_W-1:0] m;
    m = {1'b0, mag};
    return sign ? -m : m;
  endfunction

  assign is_digit = (key_code <= 4'd9);

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
    state_d  = state_q;
    mag1_d   = mag1_q;
    mag2_d   = mag2_q;
    sign1_d  = sign1_q;
    sign2_d  = sign2_q;
    cnt1_d   = cnt1_q;
    cnt2_d   = cnt2_q;
    tmo_d    = tmo_q;
    result_d = result_q;
    rv_d     = rv_q;
    err_d    = err_q;

    unique case (state_q)
      S_OP1: if (key_valid) begin
        if (is_digit) begin
          if (cnt1_q < MAX_CNT) begin
            mag1_d = append_digit(mag1_q, key_code);
            cnt1_d = cnt1_q + 1'b1;
          end
        end else if (key_code == KEY_ENTER) begin
          state_d = S_OP2;
        end else if (key_code == KEY_SIGN) begin
          sign1_d = ~sign1_q;
        end else if (key_code == KEY_CLEAR) begin
          mag1_d  = '0;
          sign1_d = 1'b0;
          cnt1_d  = '0;
        end
      end
      S_OP2: if (key_valid) begin
        if (is_digit) begin
          if (cnt2_q < MAX_CNT) begin
            mag2_d = append_digit(mag2_q, key_code);
            cnt2_d = cnt2_q + 1'b1;
          end
        end else if (key_code == KEY_ENTER) begin
          state_d = S_START;
        end else if (key_code == KEY_SIGN) begin
          sign2_d = ~sign2_q;
        end else if (key_code == KEY_CLEAR) begin
          mag1_d  = '0;
          sign1_d = 1'b0;
          cnt1_d  = '0;
          mag2_d  = '0;
          sign2_d = 1'b0;
          cnt2_d  = '0;
          state_d = S_OP1;
        end
      end
      S_START: begin
        tmo_d   = '0;
        state_d = S_WAIT;
      end
      // Done takes priority over both a same-cycle key and the timeout.
      S_WAIT: begin
        if (mult_done) begin
          result_d = mult_result;
          rv_d     = 1'b1;
          err_d    = 1'b0;
          state_d  = S_SHOW;
        end else if (tmo_q == TMO_MAX) begin
          result_d = '0;
          rv_d     = 1'b0;
          err_d    = 1'b1;
          state_d  = S_SHOW;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      S_SHOW: if (key_valid) begin
        mag1_d  = '0;
        sign1_d = 1'b0;
        cnt1_d  = '0;
        mag2_d  = '0;
        sign2_d = 1'b0;
        cnt2_d  = '0;
        rv_d    = 1'b0;
        err_d   = 1'b0;
        state_d = S_OP1;
      end
      default: state_d = S_OP1;
    endcase

    numero1_d = to_tc(sign1_d, mag1_d);
    numero2_d = to_tc(sign2_d, mag2_d);
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so all flops update together.
    if (rst) begin
      state_q   <= S_OP1;
      mag1_q    <= '0;
      mag2_q    <= '0;
      sign1_q   <= 1'b0;
      sign2_q   <= 1'b0;
      cnt1_q    <= '0;
      cnt2_q    <= '0;
      numero1_q <= '0;
      numero2_q <= '0;
      tmo_q     <= '0;
      result_q  <= '0;
      rv_q      <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      mag1_q    <= mag1_d;
      mag2_q    <= mag2_d;
      sign1_q   <= sign1_d;
      sign2_q   <= sign2_d;
      cnt1_q    <= cnt1_d;
      cnt2_q    <= cnt2_d;
      numero1_q <= numero1_d;
      numero2_q <= numero2_d;
      tmo_q     <= tmo_d;
      result_q  <= result_d;
      rv_q      <= rv_d;
      err_q     <= err_d;
    end
  end

  assign numero1_o    = numero1_q;
  assign numero2_o    = numero2_q;
  assign sel_op_o     = (state_q != S_OP1);
  assign mult_start   = (state_q == S_START);
  assign busy_o       = (state_q == S_START) || (state_q == S_WAIT);
  assign result_o     = result_q;
  assign result_valid = rv_q;
  assign err_o        = err_q;

endmodule

// File: tb/tb_operand_entry_ctrl.sv
// Directed bench for operand_entry_ctrl: inputs driven and outputs sampled on
// the falling edge, expected values hand-computed per scenario.
module tb_operand_entry_ctrl;

  localparam int OP_W    = 8;
  localparam int TIMEOUT = 1023;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              key_valid = 1'b0;
  logic [3:0]        key_code = 4'h0;
  logic              mult_done = 1'b0;
  logic [2*OP_W-1:0] mult_result = '0;
  logic [OP_W-1:0]   numero1_o, numero2_o;
  logic              sel_op_o, mult_start, busy_o, result_valid, err_o;
  logic [2*OP_W-1:0] result_o;

  int checks = 0;
  int errors = 0;

  operand_entry_ctrl #(.OP_W(OP_W), .MAX_DIGITS(2), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .key_valid(key_valid), .key_code(key_code),
    .mult_done(mult_done), .mult_result(mult_result),
    .numero1_o(numero1_o), .numero2_o(numero2_o), .sel_op_o(sel_op_o),
    .mult_start(mult_start), .busy_o(busy_o), .result_o(result_o),
    .result_valid(result_valid), .err_o(err_o)
  );

  always #5 clk = ~clk;

  // One key strobe; returns on the falling edge after it was registered.
  task automatic press(input logic [3:0] k);
    @(negedge clk);
    key_valid = 1'b1;
    key_code  = k;
    @(negedge clk);
    key_valid = 1'b0;
  endtask

  task automatic pulse_done(input logic [2*OP_W-1:0] r);
    @(negedge clk);
    mult_done   = 1'b1;
    mult_result = r;
    @(negedge clk);
    mult_done   = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++; if (numero1_o !== 8'h00) begin errors++; $display("FAIL reset_n1: got %h exp 00", numero1_o); end
    checks++; if (numero2_o !== 8'h00) begin errors++; $display("FAIL reset_n2: got %h exp 00", numero2_o); end
    checks++; if ({sel_op_o, mult_start, busy_o, result_valid, err_o} !== 5'b0) begin
      errors++; $display("FAIL reset_flags: got %b exp 00000", {sel_op_o, mult_start, busy_o, result_valid, err_o}); end
    checks++; if (result_o !== 16'h0000) begin errors++; $display("FAIL reset_result: got %h exp 0000", result_o); end
  endtask

  task automatic test_basic;
    int starts;
    press(4'h4); press(4'h2);
    checks++; if (numero1_o !== 8'h2A) begin errors++; $display("FAIL basic_n1_pos: got %h exp 2a", numero1_o); end
    press(4'hB); press(4'hA);
    checks++; if (numero1_o !== 8'hD6) begin errors++; $display("FAIL basic_n1: got %h exp d6", numero1_o); end
    checks++; if (sel_op_o !== 1'b1) begin errors++; $display("FAIL basic_sel: got %b exp 1", sel_op_o); end
    press(4'h1); press(4'h5);
    checks++; if (numero2_o !== 8'h0F) begin errors++; $display("FAIL basic_n2: got %h exp 0f", numero2_o); end
    press(4'hA);
    starts = int'(mult_start);
    checks++; if (busy_o !== 1'b1) begin errors++; $display("FAIL basic_busy: got %b exp 1", busy_o); end
    for (int i = 0; i < 19; i++) begin
      @(negedge clk);
      starts += int'(mult_start);
    end
    checks++; if (starts !== 1) begin errors++; $display("FAIL basic_start_pulses: got %0d exp 1", starts); end
    mult_done = 1'b1; mult_result = 16'hFD8A;
    @(negedge clk);
    mult_done = 1'b0;
    checks++; if (result_o !== 16'hFD8A) begin errors++; $display("FAIL basic_result: got %h exp fd8a", result_o); end
    checks++; if ({result_valid, err_o, busy_o} !== 3'b100) begin
      errors++; $display("FAIL basic_show_flags: got %b exp 100", {result_valid, err_o, busy_o}); end
    checks++; if ({numero1_o, numero2_o} !== 16'hD60F) begin
      errors++; $display("FAIL basic_ops_held: got %h exp d60f", {numero1_o, numero2_o}); end
    press(4'h0);
    checks++; if ({sel_op_o, result_valid, numero1_o, numero2_o} !== 18'h0) begin
      errors++; $display("FAIL basic_exit: got %h exp 0", {sel_op_o, result_valid, numero1_o, numero2_o}); end
  endtask

  task automatic test_max_digits;
    press(4'h9); press(4'h9); press(4'h7);
    checks++; if (numero1_o !== 8'h63) begin errors++; $display("FAIL maxdig_n1: got %h exp 63", numero1_o); end
    press(4'hA);
    checks++; if ({sel_op_o, numero1_o} !== 9'h163) begin
      errors++; $display("FAIL maxdig_enter: got %h exp 163", {sel_op_o, numero1_o}); end
    press(4'hC);
    checks++; if ({sel_op_o, numero1_o} !== 9'h000) begin
      errors++; $display("FAIL op2_clear: got %h exp 000", {sel_op_o, numero1_o}); end
  endtask

  task automatic test_empty_operands;
    press(4'hB);
    checks++; if (numero1_o !== 8'h00) begin errors++; $display("FAIL empty_negzero: got %h exp 00", numero1_o); end
    press(4'hB); press(4'hA); press(4'hA);
    checks++; if (mult_start !== 1'b1) begin errors++; $display("FAIL empty_start: got %b exp 1", mult_start); end
    checks++; if ({numero1_o, numero2_o} !== 16'h0000) begin
      errors++; $display("FAIL empty_ops: got %h exp 0000", {numero1_o, numero2_o}); end
    pulse_done(16'h0000);
    checks++; if (result_valid !== 1'b1) begin errors++; $display("FAIL empty_rv: got %b exp 1", result_valid); end
    press(4'h1);
  endtask

  task automatic test_timeout;
    int n;
    press(4'h3); press(4'hA); press(4'h7); press(4'hA);
    n = 0;
    while (err_o !== 1'b1 && n < TIMEOUT + 50) begin
      @(negedge clk);
      n++;
    end
    checks++; if (n !== TIMEOUT + 2) begin errors++; $display("FAIL timeout_cycles: got %0d exp %0d", n, TIMEOUT + 2); end
    checks++; if ({err_o, result_valid, busy_o} !== 3'b100) begin
      errors++; $display("FAIL timeout_flags: got %b exp 100", {err_o, result_valid, busy_o}); end
    checks++; if (result_o !== 16'h0000) begin errors++; $display("FAIL timeout_result: got %h exp 0000", result_o); end
    press(4'h2);
    checks++; if ({err_o, sel_op_o, numero1_o} !== 10'h0) begin
      errors++; $display("FAIL timeout_exit: got %h exp 0", {err_o, sel_op_o, numero1_o}); end
  endtask

  task automatic test_done_at_timeout;
    press(4'hA); press(4'hA);
    repeat (TIMEOUT + 1) @(negedge clk);
    checks++; if ({busy_o, err_o} !== 2'b10) begin
      errors++; $display("FAIL edge_pre: got %b exp 10", {busy_o, err_o}); end
    mult_done = 1'b1; mult_result = 16'h0055;
    @(negedge clk);
    mult_done = 1'b0;
    checks++; if ({result_valid, err_o, result_o} !== {2'b10, 16'h0055}) begin
      errors++; $display("FAIL edge_done_wins: got %h exp %h", {result_valid, err_o, result_o}, {2'b10, 16'h0055}); end
    press(4'hF);
  endtask

  task automatic test_keys_in_wait;
    press(4'h1); press(4'h2); press(4'hA); press(4'h3); press(4'hA);
    press(4'h5); press(4'hC);
    checks++; if ({busy_o, numero1_o, numero2_o} !== {1'b1, 16'h0C03}) begin
      errors++; $display("FAIL wait_keys: got %h exp %h", {busy_o, numero1_o, numero2_o}, {1'b1, 16'h0C03}); end
    @(negedge clk);
    key_valid = 1'b1; key_code = 4'hC; mult_done = 1'b1; mult_result = 16'h0024;
    @(negedge clk);
    key_valid = 1'b0; mult_done = 1'b0;
    checks++; if ({result_valid, result_o} !== {1'b1, 16'h0024}) begin
      errors++; $display("FAIL wait_collide_result: got %h exp %h", {result_valid, result_o}, {1'b1, 16'h0024}); end
    checks++; if ({sel_op_o, numero1_o, numero2_o} !== {1'b1, 16'h0C03}) begin
      errors++; $display("FAIL wait_collide_ops: got %h exp %h", {sel_op_o, numero1_o, numero2_o}, {1'b1, 16'h0C03}); end
    press(4'h7);
    checks++; if ({sel_op_o, numero1_o} !== 9'h000) begin
      errors++; $display("FAIL show_key_consumed: got %h exp 000", {sel_op_o, numero1_o}); end
  endtask

  task automatic test_reset_in_wait;
    press(4'h6); press(4'hA); press(4'hA);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++; if ({sel_op_o, busy_o, numero1_o, result_o} !== 26'h0) begin
      errors++; $display("FAIL rstwait_state: got %h exp 0", {sel_op_o, busy_o, numero1_o, result_o}); end
    pulse_done(16'h1111);
    checks++; if ({result_valid, result_o, sel_op_o} !== 18'h0) begin
      errors++; $display("FAIL rstwait_done_ignored: got %h exp 0", {result_valid, result_o, sel_op_o}); end
    press(4'h4);
    checks++; if (numero1_o !== 8'h04) begin errors++; $display("FAIL rstwait_resume: got %h exp 04", numero1_o); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_max_digits();
    test_empty_operands();
    test_timeout();
    test_done_at_timeout();
    test_keys_in_wait();
    test_reset_in_wait();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/operand_entry_ctrl.md
Name: operand_entry_ctrl

Overview:
Sequencer between the keypad decoder and the signed multiplier.
- Takes one decoded key per strobe and builds two signed decimal operands (numero1_o, numero2_o) from digit, sign and enter keys.
- Launches the multiplier with a one-cycle start pulse, waits for its done pulse (with timeout), then holds the product for display.
- Sits between the keypad scan/debounce block (dato_o/data_available) and the multiplier datapath.

Parameters:
OP_W, 8, operand width in bits, two's complement.
MAX_DIGITS, 2, maximum decimal digits per operand. Static requirement: 10^MAX_DIGITS-1 <= 2^(OP_W-1)-1.
TIMEOUT, 1023, maximum cycles spent in WAIT before err_o is raised.

Ports:
clk  in  1  system clock; all logic on the rising edge.
rst  in  1  synchronous, active-high reset.
key_valid  in  1  one-cycle strobe; key_code is valid in this cycle.
key_code  in  4  0-9 digit, 0xA enter, 0xB sign toggle, 0xC clear; 0xD-0xF ignored.
mult_done  in  1  one-cycle pulse from the multiplier; product is valid in this cycle.
mult_result  in  2*OP_W  signed product.
numero1_o  out  OP_W  operand 1, two's complement.
numero2_o  out  OP_W  operand 2, two's complement.
sel_op_o  out  1  0 = editing operand 1, 1 = editing operand 2.
mult_start  out  1  one-cycle start pulse to the multiplier.
busy_o  out  1  high in START and WAIT.
result_o  out  2*OP_W  latched product.
result_valid  out  1  high while in SHOW with a valid product.
err_o  out  1  multiplier timeout flag.

Behaviour:
- Reset: state=OP1; both magnitudes, signs and digit counts = 0; all outputs = 0.
- Per operand registers: magnitude mag (OP_W-1 bits), sign bit, digit count (0..MAX_DIGITS).
- Operand output: numero = sign ? -mag : mag, registered. Negative zero gives 0.
- Digit key in OP1/OP2, count < MAX_DIGITS: mag <= mag*10 + d (computed at OP_W+4 bits, then truncated; no overflow by the parameter rule); count++.
- Digit key with count == MAX_DIGITS: ignored.
- Sign key (0xB): toggles the sign of the current operand. Allowed at any digit count, including 0.
- Clear key (0xC) in OP1: clears operand 1 and stays in OP1.
- Clear key in OP2: clears both operands and goes to OP1.
- Enter key (0xA): OP1 -> OP2; OP2 -> START. Zero digits is legal (operand = 0).
- START: mult_start=1 for exactly one cycle, timeout counter cleared, then -> WAIT.
- WAIT:
  - on mult_done: result_o <= mult_result, result_valid=1, err_o=0, -> SHOW.
  - when the counter reaches TIMEOUT with no done: result_o=0, result_valid=0, err_o=1, -> SHOW.
- SHOW: outputs held. Any key_valid clears both operands, result_valid and err_o, and goes to OP1. That key is consumed and has no other effect.
- Keys in START/WAIT are ignored, not queued.
- mult_done outside WAIT is ignored.
- Simultaneous key_valid and mult_done in WAIT: done is processed, key dropped.
- Done arriving in the same cycle the counter reaches TIMEOUT: done wins (no error).
- Reset mid-WAIT: immediate return to OP1; a later mult_done is ignored.
- numero1_o/numero2_o stay stable from the enter in OP2 until leaving SHOW.
- sel_op_o = 1 in OP2, START, WAIT and SHOW; 0 in OP1.
- Latency: operand outputs update 1 cycle after key_valid. mult_start is asserted the cycle after the OP2 enter is registered.

Test Plan:
- Keys 4,2,B,A,1,5,A; done after 20 cycles with 0xFD8A -> numero1_o=0xD6 (-42), numero2_o=0x0F, one mult_start pulse, result_o=0xFD8A, result_valid=1.
- Keys 9,9,7,A -> third digit ignored, numero1_o=0x63 (99), sel_op_o=1.
- Keys B,B,A,A -> numero1_o=0, numero2_o=0, mult_start pulses (empty operands legal).
- Enter in OP2, no mult_done for TIMEOUT cycles -> err_o=1, result_valid=0; next key -> OP1, err_o=0.
- In WAIT, keys 5 and C plus a mult_done landing in the same cycle as a key -> keys ignored, product latched, operands unchanged.
- rst asserted during WAIT, then mult_done -> state OP1, outputs 0, done ignored, result_valid stays 0.
